// File: rtl/lane4_serializer.sv
// lane4_serializer: collects one four-lane butterfly group into a holding
// register and replays it as a single word stream, lane 0 first, each word
// tagged with its 2-bit lane index. A new group can be taken in the same
// cycle the last word of the current group leaves, so a steady upstream
// sustains one word per cycle.
module lane4_serializer #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in0,
  input  logic [WORD_SIZE-1:0] in1,
  input  logic [WORD_SIZE-1:0] in2,
  input  logic [WORD_SIZE-1:0] in3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [1:0]           out_sel,
  output logic                 out_last
);

  typedef enum logic {IDLE, SEND} state_e;

  localparam logic [1:0] LAST_LANE = 2'd3;

  state_e                     state_q, state_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic [3:0][WORD_SIZE-1:0]  hold_q, hold_d;

  logic sending;
  logic accept;
  logic fire;

  // Handshake and output decode; out_* depend on registered state only.
  always_comb begin
    sending   = (state_q == SEND);
    in_ready  = !rst && (!sending || ((cnt_q == LAST_LANE) && out_ready));
    accept    = in_valid && in_ready;
    fire      = sending && out_ready;
    out_valid = sending;
    out_data  = sending ? hold_q[cnt_q] : '0;
    out_sel   = sending ? cnt_q : 2'd0;
    out_last  = sending && (cnt_q == LAST_LANE);
  end

  // Next state: an accept (from IDLE, or overlapping the final word) reloads
  // the group; otherwise a consumed word advances the lane or ends the group.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    if (accept) begin
      hold_d  = {in3, in2, in1, in0};
      cnt_d   = 2'd0;
      state_d = SEND;
    end else if (fire) begin
      if (cnt_q != LAST_LANE) begin
        cnt_d = cnt_q + 2'd1;
      end else begin
        cnt_d   = 2'd0;
        state_d = IDLE;
      end
    end
  end

  // State registers with synchronous reset that drops any in-flight group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_lane4_serializer.sv
// Bench for lane4_serializer: a 16-bit and an 8-bit instance share control
// and see the same groups (the 8-bit one gets the low bytes). The reference
// is a word queue: an accepted group appends its four words, a consumed word
// pops the front, and the output/ready expectations follow from queue depth.
module tb_lane4_serializer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready, in_ready8;
  logic [W-1:0] in0, in1, in2, in3;
  logic         out_ready;
  logic         out_valid, out_last;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_valid8, out_last8;
  logic [7:0]   out_data8;
  logic [1:0]   out_sel8;

  int checks = 0;
  int errors = 0;
  bit rnd_mode = 1'b0;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  sel;
    logic        last;
  } word_t;

  word_t exp_q[$];

  always #5 clk = ~clk;

  lane4_serializer #(.WORD_SIZE(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_last(out_last)
  );

  lane4_serializer #(.WORD_SIZE(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in0(in0[7:0]), .in1(in1[7:0]), .in2(in2[7:0]), .in3(in3[7:0]),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .out_sel(out_sel8), .out_last(out_last8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check both DUTs at the falling edge, then advance the model
  // across the rising edge. acc reports whether the group on in* was taken.
  task automatic cycle(output bit acc);
    word_t f;
    bit    ev, er;
    logic [3:0][15:0] lanes;
    if (rnd_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    ev = (exp_q.size() > 0);
    er = !rst && ((exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready));
    f  = ev ? exp_q[0] : '0;
    chk("out_valid",  out_valid,  ev);
    chk("out_data",   out_data,   f.data);
    chk("out_sel",    out_sel,    f.sel);
    chk("out_last",   out_last,   f.last);
    chk("in_ready",   in_ready,   er);
    chk("out_valid8", out_valid8, ev);
    chk("out_data8",  out_data8,  f.data[7:0]);
    chk("out_sel8",   out_sel8,   f.sel);
    chk("out_last8",  out_last8,  f.last);
    chk("in_ready8",  in_ready8,  er);
    acc   = in_valid && er;
    lanes = {in3, in2, in1, in0};
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
    end else begin
      if (ev && out_ready) void'(exp_q.pop_front());
      if (acc)
        for (int i = 0; i < 4; i++)
          exp_q.push_back({lanes[i], 2'(i), (i == 3)});
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(a);
  endtask

  // Present a group and hold it until accepted; in_valid is left high so the
  // caller can chain groups back to back. waited = cycles until acceptance.
  task automatic send(input logic [15:0] a, b, c, d, output int waited);
    bit acc;
    in_valid = 1'b1;
    in0 = a; in1 = b; in2 = c; in3 = d;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 200) begin
      cycle(acc);
      waited++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: observed no accept after %0d cycles, expected accept", waited);
    end
  endtask

  initial begin
    int n;
    bit a;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    @(posedge clk); #1;
    idle(2);                                   // reset state, in_ready forced 0
    rst = 1'b0;
    idle(1);

    // Single group after reset; latency and in_ready return.
    send(16'h1111, 16'h2222, 16'h3333, 16'h4444, n);
    chk("first_accept_wait", n, 1);
    in_valid = 1'b0;
    idle(6);

    // Back-to-back groups: B waits exactly four cycles, no bubble.
    send(16'hA000, 16'hA001, 16'hA002, 16'hA003, n);
    send(16'hB000, 16'hB001, 16'hB002, 16'hB003, n);
    chk("b2b_accept_wait", n, 4);
    in_valid = 1'b0;
    idle(6);

    // Backpressure while lane 1 is shown.
    send(16'hC000, 16'hC001, 16'hC002, 16'hC003, n);
    in_valid = 1'b0;
    idle(1);
    out_ready = 1'b0;
    idle(3);
    out_ready = 1'b1;
    idle(5);

    // Busy rejection with a stall inside the group.
    send(16'hD000, 16'hD001, 16'hD002, 16'hD003, n);
    send(16'hE000, 16'hE001, 16'hE002, 16'hE003, n);
    chk("busy_accept_wait", n, 4);
    in_valid = 1'b0;
    idle(1);
    out_ready = 1'b0;
    idle(2);
    out_ready = 1'b1;
    idle(6);

    // Reset while lane 2 is shown: remainder discarded, restart from lane 0.
    send(16'hF000, 16'hF001, 16'hF002, 16'hF003, n);
    in_valid = 1'b0;
    idle(2);
    chk("pre_reset_sel", out_sel, 2'd2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    send(16'h12FF, 16'h3400, 16'h5680, 16'h787F, n);   // 8-bit lanes FF,00,80,7F
    in_valid = 1'b0;
    idle(6);

    // Randomized groups, gaps, backpressure and occasional reset.
    rnd_mode = 1'b1;
    for (int g = 0; g < 60; g++) begin
      send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), n);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in0 = 16'($urandom);
        idle($urandom_range(1, 4));
      end
    end
    rnd_mode = 1'b0;
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    idle(8);
    cycle(a);
    chk("drained_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lane4_serializer.md
Name: lane4_serializer

Overview:
- Re-serializes four parallel WORD_SIZE lanes (one FFT butterfly group) into a single word stream, lane 0 first.
- Acts as the collection end of the 1-to-4 lane distribution in the 16-point FFT datapath.
- Carries a 2-bit lane index per output word, with the same encoding as the distribution side's `sel`.
- Uses valid/ready handshakes on both sides and a one-group holding register.

Parameters:
- WORD_SIZE, 16, width of each lane word and of the output word.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a four-word group is present on in0..in3.
- in_ready  output  1  the block accepts the group this cycle.
- in0  input  WORD_SIZE  lane 0 word.
- in1  input  WORD_SIZE  lane 1 word.
- in2  input  WORD_SIZE  lane 2 word.
- in3  input  WORD_SIZE  lane 3 word.
- out_valid  output  1  out_data/out_sel/out_last are valid.
- out_ready  input  1  downstream consumes the word this cycle.
- out_data  output  WORD_SIZE  current serialized word.
- out_sel  output  2  lane index of out_data (00=in0 .. 11=in3).
- out_last  output  1  high with lane 3 word (end of group).

Behaviour:
- Reset (rst high at a rising edge):
  - state <= IDLE, lane counter <= 0, holding register <= 0.
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - in_ready is forced 0 while rst is high.
  - Reset overrides any handshake in the same cycle.
  - A partially emitted group is discarded; no further words of it appear.
- FSM states: IDLE, SEND.
- in_ready (combinational, rst low) = (state==IDLE) OR (state==SEND AND cnt==3 AND out_ready).
- Accept: in_valid AND in_ready at a rising edge.
  - Latches in0..in3 into the holding register.
  - cnt <= 0, state <= SEND.
- SEND:
  - out_valid=1, out_data=hold[cnt], out_sel=cnt, out_last=(cnt==3).
  - Outputs are registered or decoded from registered state only; there is no combinational path from in_* to out_*.
- Output handshake: out_valid AND out_ready at an edge.
  - cnt<3: cnt <= cnt+1.
  - cnt==3 with a new accept in the same cycle: reload holding register, cnt <= 0, stay in SEND (back-to-back, no bubble).
  - cnt==3 without an accept: state <= IDLE, out_valid <= 0.
- Backpressure: out_ready low holds cnt, out_data, out_sel and out_last stable; out_valid stays high.
- Latency: first word is valid the cycle after acceptance.
  - Sustained throughput is 1 word/cycle (4 cycles per group) when out_ready is held high.
- in_valid while busy (SEND, cnt<3, or cnt==3 with out_ready low): in_ready=0, so the group is not taken. Upstream must hold in_valid and in0..in3 stable until accepted.
- Data path is pure pass-through: no width change, no arithmetic, no reordering other than lane 0..3 order.
- Lane counter is 2 bits and never wraps past 3 without a group reload or return to IDLE.

Test Plan:
- Reset release, single group: in0..in3=0x1111,0x2222,0x3333,0x4444, out_ready=1 -> out_valid on cycles T+1..T+4 with out_data 1111,2222,3333,4444, out_sel 0,1,2,3, out_last only on 4444; in_ready high again at T+4.
- Back-to-back: groups A(0xA000..A003) and B(0xB000..B003), in_valid held, out_ready=1 -> 8 consecutive valid words, no bubble; B accepted in the cycle A003 is consumed.
- Backpressure: out_ready low for 3 cycles while out_sel=1 -> out_data and out_sel=1 held stable, out_valid=1, in_ready=0; on resume, sequence continues at lane 2.
- Busy rejection: second group presented while cnt=1 -> in_ready=0; group accepted only at the cnt==3 handshake; no words lost or duplicated.
- Reset mid-group: rst high while out_sel=2 -> next cycle out_valid=0, out_data=0, out_sel=0; lane 3 of the interrupted group never appears; a new group afterwards serializes normally from lane 0.
- WORD_SIZE=8 instance: lanes 0xFF,0x00,0x80,0x7F -> emitted unchanged in order with correct out_sel and out_last.
